// File: rtl/pc_return_stack.sv
// pc_return_stack: return-address stack feeding FROM_STACK of the RAT MCU program counter.
// Optional feature: define RETSTACK_WRAP_EN so a push while full overwrites the oldest entry.
module pc_return_stack #(
    parameter int DEPTH = 16,
    parameter int AW    = 10
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    PUSH,
    input  logic                    POP,
    input  logic [AW-1:0]           PC_COUNT,
    output logic [AW-1:0]           FROM_STACK,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] tp;
    logic [PW-1:0] tp_next;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] wr_idx;
    logic [CW-1:0] count_next;
    logic [AW-1:0] push_val;
    logic          wr_en;
    logic          ovf_set;
    logic          unf_set;

    // Return address wraps modulo 2^AW, so a CALL at the last ROM word returns to 0.
    assign push_val   = PC_COUNT + AW'(1);
    assign top_idx    = tp - PW'(1);
    assign EMPTY      = (COUNT == '0);
    assign FULL       = (COUNT == COUNT_MAX);
    assign FROM_STACK = EMPTY ? '0 : mem[top_idx];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        wr_en      = 1'b0;
        wr_idx     = tp;
        tp_next    = tp;
        count_next = COUNT;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case ({PUSH, POP})
            2'b10: begin
                if (!FULL) begin
                    wr_en      = 1'b1;
                    tp_next    = tp + PW'(1);
                    count_next = COUNT + CW'(1);
                end else begin
`ifdef RETSTACK_WRAP_EN
                    // Oldest entry sits at tp when full; overwrite it and keep COUNT pinned.
                    wr_en   = 1'b1;
                    tp_next = tp + PW'(1);
`else
                    ovf_set = 1'b1;
`endif
                end
            end
            2'b01: begin
                if (!EMPTY) begin
                    tp_next    = top_idx;
                    count_next = COUNT - CW'(1);
                end else begin
                    unf_set = 1'b1;
                end
            end
            2'b11: begin
                if (EMPTY) begin
                    // Nothing to return from: treat as a plain CALL (DEPTH >= 2, so never full here).
                    wr_en      = 1'b1;
                    tp_next    = tp + PW'(1);
                    count_next = COUNT + CW'(1);
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
        if (!RST) begin
            tp        <= '0;
            COUNT     <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            tp        <= tp_next;
            COUNT     <= count_next;
            OVERFLOW  <= OVERFLOW | ovf_set;
            UNDERFLOW <= UNDERFLOW | unf_set;
        end
    end

    // NOTE: the array has no reset; an entry is always written before COUNT exposes it on FROM_STACK.
    always_ff @(posedge CLK) begin
        if (wr_en && RST) begin
            mem[wr_idx] <= push_val;
        end
    end

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed self-checking bench for pc_return_stack (DEPTH=16, AW=10).
// Expectations follow RETSTACK_WRAP_EN when it is defined for the build.
module tb_pc_return_stack;

    localparam int DEPTH = 16;
    localparam int AW    = 10;

    logic                   CLK;
    logic                   RST;
    logic                   PUSH;
    logic                   POP;
    logic [AW-1:0]          PC_COUNT;
    logic [AW-1:0]          FROM_STACK;
    logic                   EMPTY;
    logic                   FULL;
    logic [$clog2(DEPTH):0] COUNT;
    logic                   OVERFLOW;
    logic                   UNDERFLOW;

    int checks   = 0;
    int failures = 0;

    pc_return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PUSH      (PUSH),
        .POP       (POP),
        .PC_COUNT  (PC_COUNT),
        .FROM_STACK(FROM_STACK),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .COUNT     (COUNT),
        .OVERFLOW  (OVERFLOW),
        .UNDERFLOW (UNDERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Apply strobes for exactly one rising edge, then leave the bench 1 time unit after it.
    task automatic op(input logic push, input logic pop, input logic [AW-1:0] pc);
        PUSH     = push;
        POP      = pop;
        PC_COUNT = pc;
        @(posedge CLK);
        #1;
        PUSH = 1'b0;
        POP  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 16'(COUNT), 16'd0);
        check({tag, "_empty"}, 16'(EMPTY), 16'd1);
        check({tag, "_full"},  16'(FULL),  16'd0);
        check({tag, "_top"},   16'(FROM_STACK), 16'h000);
        check({tag, "_ovf"},   16'(OVERFLOW),  16'd0);
        check({tag, "_unf"},   16'(UNDERFLOW), 16'd0);
    endtask

    initial begin
        RST      = 1'b0;
        PUSH     = 1'b0;
        POP      = 1'b0;
        PC_COUNT = '0;
        #11;
        check_reset_outputs("reset");
        RST = 1'b1;

        // Single CALL from 0x012.
        op(1'b1, 1'b0, 10'h012);
        check("push1_top",   16'(FROM_STACK), 16'h013);
        check("push1_count", 16'(COUNT), 16'd1);
        check("push1_empty", 16'(EMPTY), 16'd0);
        check("pop1_during", 16'(FROM_STACK), 16'h013);
        op(1'b0, 1'b1, 10'h000);
        check("pop1_empty",  16'(EMPTY), 16'd1);

        // Three nested CALLs then three RETs, newest first.
        op(1'b1, 1'b0, 10'h010);
        op(1'b1, 1'b0, 10'h020);
        op(1'b1, 1'b0, 10'h030);
        check("lifo_count", 16'(COUNT), 16'd3);
        check("lifo_pop0", 16'(FROM_STACK), 16'h031);
        op(1'b0, 1'b1, 10'h000);
        check("lifo_pop1", 16'(FROM_STACK), 16'h021);
        op(1'b0, 1'b1, 10'h000);
        check("lifo_pop2", 16'(FROM_STACK), 16'h011);
        op(1'b0, 1'b1, 10'h000);
        check("lifo_empty", 16'(EMPTY), 16'd1);
        check("lifo_top0",  16'(FROM_STACK), 16'h000);
        check("lifo_unf0",  16'(UNDERFLOW), 16'd0);

        // RET with nothing on the stack.
        op(1'b0, 1'b1, 10'h000);
        check("unf_flag",  16'(UNDERFLOW), 16'd1);
        check("unf_top",   16'(FROM_STACK), 16'h000);
        check("unf_count", 16'(COUNT), 16'd0);

        // PUSH+POP while empty acts as a push and does not touch UNDERFLOW.
        op(1'b1, 1'b1, 10'h100);
        check("pp_empty_count", 16'(COUNT), 16'd1);
        check("pp_empty_top",   16'(FROM_STACK), 16'h101);
        op(1'b1, 1'b0, 10'h3FE);
        check("push_3fe_top", 16'(FROM_STACK), 16'h3FF);

        // PUSH+POP at COUNT=2 from 0x3FF replaces the top with the wrapped address 0x000.
        op(1'b1, 1'b1, 10'h3FF);
        check("pp_wrap_top",   16'(FROM_STACK), 16'h000);
        check("pp_wrap_count", 16'(COUNT), 16'd2);
        op(1'b0, 1'b1, 10'h000);
        check("pp_below_top", 16'(FROM_STACK), 16'h101);
        op(1'b0, 1'b1, 10'h000);
        check("pp_drain_empty", 16'(EMPTY), 16'd1);
        check("unf_sticky",     16'(UNDERFLOW), 16'd1);

        // Asynchronous reset between edges with five entries held.
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 10'(i));
        check("pre_arst_count", 16'(COUNT), 16'd5);
        #2;
        RST = 1'b0;
        #1;
        check_reset_outputs("arst");
        #2;
        RST = 1'b1;

        // Seventeen CALLs into a sixteen-deep stack; push i stores 0x10*i + 1.
        for (int i = 1; i <= 16; i++) op(1'b1, 1'b0, 10'(16 * i));
        check("fill_count", 16'(COUNT), 16'd16);
        check("fill_full",  16'(FULL),  16'd1);
        check("fill_ovf",   16'(OVERFLOW), 16'd0);
        op(1'b1, 1'b0, 10'(16 * 17));
        check("over_count", 16'(COUNT), 16'd16);
        check("over_full",  16'(FULL),  16'd1);
`ifdef RETSTACK_WRAP_EN
        check("over_ovf", 16'(OVERFLOW), 16'd0);
        check("over_top", 16'(FROM_STACK), 16'h111);
        for (int i = 17; i >= 2; i--) begin
            check($sformatf("drain_%0d", i), 16'(FROM_STACK), 16'(16 * i + 1));
            op(1'b0, 1'b1, 10'h000);
        end
`else
        check("over_ovf", 16'(OVERFLOW), 16'd1);
        check("over_top", 16'(FROM_STACK), 16'h101);
        for (int i = 16; i >= 1; i--) begin
            check($sformatf("drain_%0d", i), 16'(FROM_STACK), 16'(16 * i + 1));
            op(1'b0, 1'b1, 10'h000);
        end
`endif
        check("drain_empty", 16'(EMPTY), 16'd1);
        check("drain_top",   16'(FROM_STACK), 16'h000);
        check("drain_unf",   16'(UNDERFLOW), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
